c_hot_count_mon: RTL and testbench

Registered, parametrised hot-count monitor for grant, select and state vectors. Each cycle it samples a qualified input vector and computes its population count. It flags vectors whose count exceeds a programmable maximum, and optionally flags all-zero vectors. Violations are accumulated in a sticky flag, a saturating counter and a first-error capture register. Instantiated beside allocators, arbiters and crossbar control as a synthesizable run-time checker whose status is readable by software and by the bench.

---
 rtl/c_constants.sv | 23 ++
 rtl/c_popcount.sv | 33 +++
 rtl/c_hot_count_mon.sv | 139 +++++++++++++
 tb/tb_c_hot_count_mon.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/c_constants.sv
// Shared constants for the hot-count monitor family.
//   KIND_*  : violation classification codes (2'b11 reserved, never produced)
//   KIND_W  : width of a kind code
//   clogb() : ceiling log2, used to size population-count results
package c_constants;

    localparam int KIND_W = 2;

    typedef enum logic [KIND_W-1:0] {
        KIND_NONE  = 2'b00,
        KIND_ZERO  = 2'b01,
        KIND_MULTI = 2'b10
    } kind_e;

    // Smallest r with 2**r >= v; clogb(1) = 0.
    function automatic int clogb(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/c_popcount.sv
// Combinational population count as a balanced binary adder tree.
//   data  : input vector, width bits
//   count : number of set bits, clogb(width+1) bits
module c_popcount
    import c_constants::*;
#(
    parameter int width = 8
) (
    input  logic [0:width-1]              data,
    output logic [clogb(width+1)-1:0]     count
);

    localparam int CW = clogb(width + 1);
    localparam int NP = 1 << clogb(width);   // leaves, padded to a power of two

    // Heap-ordered tree: node i has children 2i+1 / 2i+2, leaves start at NP-1.
    logic [CW-1:0] node [2*NP-1];

    for (genvar j = 0; j < NP; j++) begin : g_leaf
        if (j < width) begin : g_bit
            assign node[NP-1+j] = CW'(data[j]);
        end else begin : g_pad
            assign node[NP-1+j] = '0;
        end
    end

    for (genvar i = 0; i < NP - 1; i++) begin : g_add
        assign node[i] = node[2*i+1] + node[2*i+2];
    end

    assign count = node[0];

endmodule

// File: rtl/c_hot_count_mon.sv
// Run-time hot-count checker for grant / select / state vectors.
// Classifies each qualified vector by popcount, pulses err on a violation and
// keeps sticky, saturating-count and first-error status until clear.
//   clk, reset_n      : clock, synchronous active-low reset
//   valid, data       : qualified monitored vector
//   clear             : wipe sticky / count / capture (next edge)
//   err, err_kind     : one-cycle violation pulse and its kind
//   hot_count         : popcount of last qualified vector
//   err_sticky        : any violation since reset/clear
//   err_count         : saturating violation count
//   first_kind/_data  : capture of the first violation since reset/clear
module c_hot_count_mon
    import c_constants::*;
#(
    parameter int width       = 8,
    parameter int max_hot     = 1,
    parameter int allow_zero  = 1,
    parameter int count_width = 8,
    parameter int pipelined   = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        valid,
    input  logic [0:width-1]            data,
    input  logic                        clear,
    output logic                        err,
    output logic [KIND_W-1:0]           err_kind,
    output logic [clogb(width+1)-1:0]   hot_count,
    output logic                        err_sticky,
    output logic [count_width-1:0]      err_count,
    output logic [KIND_W-1:0]           first_kind,
    output logic [0:width-1]            first_data
);

    localparam int HW = clogb(width + 1);
    localparam logic [count_width-1:0] CNT_MAX = '1;

    // Optional input register stage.
    logic             s1_vld;
    logic [0:width-1] s1_data;

    if (pipelined != 0) begin : g_pipe
        logic             vld_q;
        logic [0:width-1] data_q;
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else begin
                vld_q  <= valid;
                data_q <= data;
            end
        end
        assign s1_vld  = vld_q;
        assign s1_data = data_q;
    end else begin : g_direct
        assign s1_vld  = valid;
        assign s1_data = data;
    end

    logic [HW-1:0] n;

    c_popcount #(.width(width)) u_popcount (
        .data  (s1_data),
        .count (n)
    );

    kind_e kind_d;
    logic  viol;

    always_comb begin
        kind_d = KIND_NONE;
        if (s1_vld) begin
            if (n > HW'(max_hot))
                kind_d = KIND_MULTI;
            else if (n == '0 && allow_zero == 0)
                kind_d = KIND_ZERO;
        end
    end

    assign viol = (kind_d != KIND_NONE);

    // Status next-state: clear wipes first, then a coincident violation lands
    // on the wiped state (clear-then-set).
    logic                   err_q, sticky_q, sticky_d;
    kind_e                  kind_q, fkind_q, fkind_d, base_fkind;
    logic [HW-1:0]          hot_q;
    logic [count_width-1:0] cnt_q, cnt_d, base_cnt;
    logic [0:width-1]       fdata_q, fdata_d, base_fdata;

    always_comb begin
        base_cnt   = clear ? '0 : cnt_q;
        base_fkind = clear ? KIND_NONE : fkind_q;
        base_fdata = clear ? '0 : fdata_q;
        sticky_d   = clear ? 1'b0 : sticky_q;
        cnt_d      = base_cnt;
        fkind_d    = base_fkind;
        fdata_d    = base_fdata;
        if (viol) begin
            sticky_d = 1'b1;
            if (base_cnt != CNT_MAX)
                cnt_d = base_cnt + 1'b1;
            if (base_fkind == KIND_NONE) begin
                fkind_d = kind_d;
                fdata_d = s1_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q    <= 1'b0;
            kind_q   <= KIND_NONE;
            hot_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            fkind_q  <= KIND_NONE;
            fdata_q  <= '0;
        end else begin
            err_q    <= viol;
            kind_q   <= kind_d;
            if (s1_vld)
                hot_q <= n;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            fkind_q  <= fkind_d;
            fdata_q  <= fdata_d;
        end
    end

    assign err        = err_q;
    assign err_kind   = kind_q;
    assign hot_count  = hot_q;
    assign err_sticky = sticky_q;
    assign err_count  = cnt_q;
    assign first_kind = fkind_q;
    assign first_data = fdata_q;

endmodule

// File: tb/tb_c_hot_count_mon.sv
// Directed bench for c_hot_count_mon. Four instances share the 8-bit stimulus:
//   A: width 8, max 1, zero legal, pipelined
//   B: width 8, max 1, zero illegal, unpipelined
//   C: width 8, max 1, zero legal, pipelined, 2-bit counter
//   D: width 1, max 0, zero illegal, unpipelined
module tb_c_hot_count_mon;
    import c_constants::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       valid = 1'b0;
    logic [0:7] data = '0;
    logic       clear = 1'b0;
    logic       valid_d = 1'b0;
    logic [0:0] data_d = '0;

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic       err_a, sticky_a;  logic [1:0] kind_a, fk_a;  logic [3:0] hot_a;
    logic [7:0] cnt_a;            logic [0:7] fd_a;
    logic       err_b, sticky_b;  logic [1:0] kind_b, fk_b;  logic [3:0] hot_b;
    logic [7:0] cnt_b;            logic [0:7] fd_b;
    logic       err_c, sticky_c;  logic [1:0] kind_c, fk_c;  logic [3:0] hot_c;
    logic [1:0] cnt_c;            logic [0:7] fd_c;
    logic       err_d, sticky_d;  logic [1:0] kind_d, fk_d;  logic [0:0] hot_d;
    logic [7:0] cnt_d;            logic [0:0] fd_d;

    c_hot_count_mon #(.width(8), .max_hot(1), .allow_zero(1), .count_width(8), .pipelined(1)) u_a (
        .clk(clk), .reset_n(reset_n), .valid(valid), .data(data), .clear(clear),
        .err(err_a), .err_kind(kind_a), .hot_count(hot_a), .err_sticky(sticky_a),
        .err_count(cnt_a), .first_kind(fk_a), .first_data(fd_a));

    c_hot_count_mon #(.width(8), .max_hot(1), .allow_zero(0), .count_width(8), .pipelined(0)) u_b (
        .clk(clk), .reset_n(reset_n), .valid(valid), .data(data), .clear(clear),
        .err(err_b), .err_kind(kind_b), .hot_count(hot_b), .err_sticky(sticky_b),
        .err_count(cnt_b), .first_kind(fk_b), .first_data(fd_b));

    c_hot_count_mon #(.width(8), .max_hot(1), .allow_zero(1), .count_width(2), .pipelined(1)) u_c (
        .clk(clk), .reset_n(reset_n), .valid(valid), .data(data), .clear(clear),
        .err(err_c), .err_kind(kind_c), .hot_count(hot_c), .err_sticky(sticky_c),
        .err_count(cnt_c), .first_kind(fk_c), .first_data(fd_c));

    c_hot_count_mon #(.width(1), .max_hot(0), .allow_zero(0), .count_width(8), .pipelined(0)) u_d (
        .clk(clk), .reset_n(reset_n), .valid(valid_d), .data(data_d), .clear(clear),
        .err(err_d), .err_kind(kind_d), .hot_count(hot_d), .err_sticky(sticky_d),
        .err_count(cnt_d), .first_kind(fk_d), .first_data(fd_d));

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0; valid_d = 1'b0; clear = 1'b0; data = '0; data_d = '0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [22:0] st;
        do_reset();
        st = {err_a, kind_a, hot_a, sticky_a, cnt_a, fk_a, fd_a[0:1]};
        n_vec++;
        if (st !== '0 || fd_a !== 8'h00) begin
            n_bad++; $display("FAIL reset_a got %h/%h want 0", st, fd_a);
        end
        n_vec++;
        if ({err_d, kind_d, hot_d, sticky_d, cnt_d, fk_d, fd_d} !== '0) begin
            n_bad++; $display("FAIL reset_d got %h want 0", {err_d, kind_d, hot_d, sticky_d, cnt_d, fk_d, fd_d});
        end
    endtask

    task automatic test_basic();
        do_reset();
        valid = 1'b1; data = 8'h00; tick();
        data = 8'h10; tick();
        n_vec++;
        if (err_a !== 1'b0 || hot_a !== 4'd0) begin
            n_bad++; $display("FAIL basic_00 err %b hot %0d want 0 0", err_a, hot_a);
        end
        data = 8'h18; tick();
        n_vec++;
        if (err_a !== 1'b0 || hot_a !== 4'd1) begin
            n_bad++; $display("FAIL basic_10 err %b hot %0d want 0 1", err_a, hot_a);
        end
        valid = 1'b0; tick();
        n_vec++;
        if (err_a !== 1'b1 || kind_a !== KIND_MULTI || hot_a !== 4'd2) begin
            n_bad++; $display("FAIL basic_18 err %b kind %0d hot %0d want 1 2 2", err_a, kind_a, hot_a);
        end
        n_vec++;
        if (fd_a !== 8'h18 || cnt_a !== 8'd1 || sticky_a !== 1'b1 || fk_a !== KIND_MULTI) begin
            n_bad++; $display("FAIL basic_status fd %h cnt %0d st %b fk %0d want 18 1 1 2", fd_a, cnt_a, sticky_a, fk_a);
        end
        tick();
        n_vec++;
        if (err_a !== 1'b0 || kind_a !== KIND_NONE || hot_a !== 4'd2 || cnt_a !== 8'd1) begin
            n_bad++; $display("FAIL basic_idle err %b kind %0d hot %0d cnt %0d want 0 0 2 1", err_a, kind_a, hot_a, cnt_a);
        end
    endtask

    task automatic test_zero();
        do_reset();
        valid = 1'b1; data = 8'h00; tick();
        n_vec++;
        if (err_b !== 1'b1 || kind_b !== KIND_ZERO || cnt_b !== 8'd1 || fk_b !== KIND_ZERO) begin
            n_bad++; $display("FAIL zero_first err %b kind %0d cnt %0d fk %0d want 1 1 1 1", err_b, kind_b, cnt_b, fk_b);
        end
        data = 8'hFF; tick();
        n_vec++;
        if (err_b !== 1'b1 || kind_b !== KIND_MULTI || hot_b !== 4'd8 || cnt_b !== 8'd2) begin
            n_bad++; $display("FAIL zero_ff err %b kind %0d hot %0d cnt %0d want 1 2 8 2", err_b, kind_b, hot_b, cnt_b);
        end
        n_vec++;
        if (fk_b !== KIND_ZERO || fd_b !== 8'h00) begin
            n_bad++; $display("FAIL zero_capture fk %0d fd %h want 1 00", fk_b, fd_b);
        end
        valid = 1'b0; tick();
        n_vec++;
        if (err_b !== 1'b0 || cnt_b !== 8'd2) begin
            n_bad++; $display("FAIL zero_idle err %b cnt %0d want 0 2", err_b, cnt_b);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [1:5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        valid = 1'b1; data = 8'hFF; tick();
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) valid = 1'b0;
            tick();
            n_vec++;
            if (err_c !== 1'b1 || sticky_c !== 1'b1 || cnt_c !== exp_cnt[i]) begin
                n_bad++; $display("FAIL sat_%0d err %b st %b cnt %0d want 1 1 %0d", i, err_c, sticky_c, cnt_c, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_clear_collide();
        do_reset();
        valid = 1'b1; data = 8'hFF; tick();
        data = 8'h81; tick();
        n_vec++;
        if (cnt_a !== 8'd1 || fd_a !== 8'hFF) begin
            n_bad++; $display("FAIL clr_pre cnt %0d fd %h want 1 ff", cnt_a, fd_a);
        end
        valid = 1'b0; clear = 1'b1; tick();
        n_vec++;
        if (err_a !== 1'b1 || sticky_a !== 1'b1 || cnt_a !== 8'd1 || fd_a !== 8'h81 || fk_a !== KIND_MULTI) begin
            n_bad++; $display("FAIL clr_collide err %b st %b cnt %0d fd %h fk %0d want 1 1 1 81 2", err_a, sticky_a, cnt_a, fd_a, fk_a);
        end
        tick();
        clear = 1'b0;
        n_vec++;
        if (sticky_a !== 1'b0 || cnt_a !== 8'd0 || fk_a !== KIND_NONE || fd_a !== 8'h00 || err_a !== 1'b0) begin
            n_bad++; $display("FAIL clr_alone st %b cnt %0d fk %0d fd %h err %b want 0 0 0 00 0", sticky_a, cnt_a, fk_a, fd_a, err_a);
        end
        n_vec++;
        if (hot_a !== 4'd2) begin
            n_bad++; $display("FAIL clr_hot got %0d want 2", hot_a);
        end
    endtask

    task automatic test_reset_flight();
        do_reset();
        valid = 1'b1; data = 8'hFF; tick();
        valid = 1'b0; reset_n = 1'b0; tick();
        n_vec++;
        if ({err_a, kind_a, hot_a, sticky_a, cnt_a, fk_a} !== '0 || fd_a !== 8'h00) begin
            n_bad++; $display("FAIL flight_reset got %h fd %h want 0", {err_a, kind_a, hot_a, sticky_a, cnt_a, fk_a}, fd_a);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (err_a !== 1'b0 || cnt_a !== 8'd0 || sticky_a !== 1'b0) begin
                n_bad++; $display("FAIL flight_after_%0d err %b cnt %0d st %b want 0 0 0", i, err_a, cnt_a, sticky_a);
            end
        end
    endtask

    task automatic test_width1();
        do_reset();
        valid_d = 1'b1; data_d = 1'b1; tick();
        n_vec++;
        if (err_d !== 1'b1 || kind_d !== KIND_MULTI || hot_d !== 1'b1) begin
            n_bad++; $display("FAIL w1_one err %b kind %0d hot %0d want 1 2 1", err_d, kind_d, hot_d);
        end
        data_d = 1'b0; tick();
        n_vec++;
        if (err_d !== 1'b1 || kind_d !== KIND_ZERO || hot_d !== 1'b0) begin
            n_bad++; $display("FAIL w1_zero err %b kind %0d hot %0d want 1 1 0", err_d, kind_d, hot_d);
        end
        valid_d = 1'b0; data_d = 1'b1; tick();
        n_vec++;
        if (err_d !== 1'b0 || kind_d !== KIND_NONE || cnt_d !== 8'd2 || fk_d !== KIND_MULTI || fd_d !== 1'b1) begin
            n_bad++; $display("FAIL w1_idle err %b kind %0d cnt %0d fk %0d fd %b want 0 0 2 2 1", err_d, kind_d, cnt_d, fk_d, fd_d);
        end
        tick();
        n_vec++;
        if (err_d !== 1'b0 || cnt_d !== 8'd2) begin
            n_bad++; $display("FAIL w1_idle2 err %b cnt %0d want 0 2", err_d, cnt_d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_saturate();
        test_clear_collide();
        test_reset_flight();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
